// File: rtl/pc_redirect_ctrl.sv
// pc_redirect_ctrl: sequencer in front of the PC. Holds the PC through a
// post-reset boot window, arbitrates exception/jump/branch redirects, parks
// a redirect that arrives during a stall, and halts fetch after an issued
// redirect to HALT_ADDR.
module pc_redirect_ctrl #(
  parameter int          BOOT_CYCLES = 3,
  parameter logic [31:0] EXC_VECTOR  = 32'hBFC00180,
  parameter logic [31:0] HALT_ADDR   = 32'h00000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_req,
  input  logic        fetch_stall,
  input  logic        br_req,
  input  logic [31:0] br_target,
  input  logic        j_req,
  input  logic [31:0] j_target,
  input  logic        exc_req,
  output logic [31:0] PC_JVal,
  output logic        branch_en,
  output logic        jump_en,
  output logic        PC_Stall,
  output logic        flush,
  output logic        active,
  output logic        halted
);

  localparam int CW = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;

  typedef enum logic [1:0] {S_BOOT, S_RUN, S_PEND, S_HALT} state_t;

  // Redirect kinds, numerically ordered by priority so a plain compare arbitrates.
  localparam logic [1:0] K_NONE = 2'd0;
  localparam logic [1:0] K_BR   = 2'd1;
  localparam logic [1:0] K_J    = 2'd2;
  localparam logic [1:0] K_EXC  = 2'd3;

  state_t      state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [1:0]  pend_kind_reg, pend_kind_next;
  logic [31:0] pend_target_reg, pend_target_next;
  logic [31:0] last_reg, last_next;

  logic        stall;
  logic [1:0]  req_kind;
  logic [31:0] req_target;
  logic [1:0]  issue_kind;
  logic [31:0] issue_target;

  // Arbitrate this cycle's incoming requests (exception > jump > branch).
  always_comb begin
    stall      = stall_req | fetch_stall;
    req_kind   = K_NONE;
    req_target = br_target;
    if (exc_req) begin
      req_kind   = K_EXC;
      req_target = EXC_VECTOR;
    end else if (j_req) begin
      req_kind   = K_J;
      req_target = j_target;
    end else if (br_req) begin
      req_kind   = K_BR;
      req_target = br_target;
    end
  end

  // State register, boot counter, pending redirect and last issued target.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= S_BOOT;
      cnt_reg         <= CW'(BOOT_CYCLES - 1);
      pend_kind_reg   <= K_NONE;
      pend_target_reg <= '0;
      last_reg        <= '0;
    end else begin
      state_reg       <= state_next;
      cnt_reg         <= cnt_next;
      pend_kind_reg   <= pend_kind_next;
      pend_target_reg <= pend_target_next;
      last_reg        <= last_next;
    end
  end

  // Next-state and output decode; an issue is combinational in its own cycle.
  always_comb begin
    state_next       = state_reg;
    cnt_next         = cnt_reg;
    pend_kind_next   = pend_kind_reg;
    pend_target_next = pend_target_reg;
    last_next        = last_reg;
    issue_kind       = K_NONE;
    issue_target     = last_reg;
    PC_Stall         = 1'b1;
    active           = 1'b0;
    halted           = 1'b0;

    case (state_reg)
      S_BOOT: begin
        if (cnt_reg == '0) state_next = S_RUN;
        else               cnt_next   = cnt_reg - CW'(1);
      end
      S_RUN: begin
        active   = 1'b1;
        PC_Stall = stall;
        if (req_kind != K_NONE) begin
          if (stall) begin
            pend_kind_next   = req_kind;
            pend_target_next = req_target;
            state_next       = S_PEND;
          end else begin
            issue_kind   = req_kind;
            issue_target = req_target;
          end
        end
      end
      S_PEND: begin
        active   = 1'b1;
        PC_Stall = stall;
        if (stall) begin
          // Only a strictly more urgent request displaces the parked one.
          if (req_kind > pend_kind_reg) begin
            pend_kind_next   = req_kind;
            pend_target_next = req_target;
          end
        end else begin
          // Stall released: issue the parked redirect; same-cycle requests are dropped.
          issue_kind     = pend_kind_reg;
          issue_target   = pend_target_reg;
          pend_kind_next = K_NONE;
          state_next     = S_RUN;
        end
      end
      S_HALT: begin
        halted = 1'b1;
      end
      default: state_next = S_BOOT;
    endcase

    if (issue_kind != K_NONE) begin
      last_next = issue_target;
      if (issue_target == HALT_ADDR) state_next = S_HALT;
    end

    PC_JVal   = issue_target;
    branch_en = (issue_kind == K_BR);
    jump_en   = (issue_kind == K_J) || (issue_kind == K_EXC);
    flush     = (issue_kind == K_EXC);
  end

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Self-checking bench for pc_redirect_ctrl: directed scenarios plus a
// randomized run, all checked against a queue-based behavioural model.
module tb_pc_redirect_ctrl;

  localparam int          BOOT_CYCLES = 3;
  localparam logic [31:0] EXC_VECTOR  = 32'hBFC00180;
  localparam logic [31:0] HALT_ADDR   = 32'h00000000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall_req = 1'b0, fetch_stall = 1'b0;
  logic        br_req = 1'b0, j_req = 1'b0, exc_req = 1'b0;
  logic [31:0] br_target = '0, j_target = '0;
  logic [31:0] PC_JVal;
  logic        branch_en, jump_en, PC_Stall, flush, active, halted;

  int tests_run = 0;
  int tests_failed = 0;

  pc_redirect_ctrl #(
    .BOOT_CYCLES(BOOT_CYCLES), .EXC_VECTOR(EXC_VECTOR), .HALT_ADDR(HALT_ADDR)
  ) dut (
    .clk(clk), .rst(rst), .stall_req(stall_req), .fetch_stall(fetch_stall),
    .br_req(br_req), .br_target(br_target), .j_req(j_req), .j_target(j_target),
    .exc_req(exc_req), .PC_JVal(PC_JVal), .branch_en(branch_en), .jump_en(jump_en),
    .PC_Stall(PC_Stall), .flush(flush), .active(active), .halted(halted)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural reference model ----------------
  typedef struct {
    int          prio;   // 3 exception, 2 jump, 1 branch
    logic [31:0] tgt;
  } redir_t;

  redir_t      m_pend[$];
  int          m_boot_left;
  bit          m_halted;
  logic [31:0] m_last;

  logic [31:0] exp_jval;
  logic        exp_br, exp_j, exp_stall, exp_flush, exp_act, exp_halt;
  logic [37:0] obs_vec, exp_vec;

  assign obs_vec = {PC_JVal, branch_en, jump_en, PC_Stall, flush, active, halted};

  function automatic void model_reset();
    m_pend.delete();
    m_boot_left = BOOT_CYCLES;
    m_halted    = 1'b0;
    m_last      = '0;
  endfunction

  function automatic redir_t model_request();
    redir_t r;
    r.prio = 0; r.tgt = '0;
    if (exc_req)     begin r.prio = 3; r.tgt = EXC_VECTOR; end
    else if (j_req)  begin r.prio = 2; r.tgt = j_target;   end
    else if (br_req) begin r.prio = 1; r.tgt = br_target;  end
    return r;
  endfunction

  function automatic redir_t model_issue();
    redir_t r;
    bit s;
    r.prio = 0; r.tgt = '0;
    s = stall_req | fetch_stall;
    if (rst || m_halted || m_boot_left > 0 || s) return r;
    if (m_pend.size() > 0) return m_pend[0];
    return model_request();
  endfunction

  function automatic void model_eval();
    redir_t is;
    exp_jval = m_last; exp_br = 0; exp_j = 0; exp_flush = 0;
    exp_stall = 1; exp_act = 0; exp_halt = 0;
    if (!rst) begin
      if (m_halted) exp_halt = 1;
      else if (m_boot_left == 0) begin
        exp_act   = 1;
        exp_stall = stall_req | fetch_stall;
        is = model_issue();
        if (is.prio > 0) begin
          exp_jval  = is.tgt;
          exp_br    = (is.prio == 1);
          exp_j     = (is.prio >= 2);
          exp_flush = (is.prio == 3);
        end
      end
    end
    exp_vec = {exp_jval, exp_br, exp_j, exp_stall, exp_flush, exp_act, exp_halt};
  endfunction

  function automatic void model_edge();
    redir_t is, rq;
    bit s;
    if (rst) begin model_reset(); return; end
    if (m_halted) return;
    if (m_boot_left > 0) begin m_boot_left--; return; end
    s  = stall_req | fetch_stall;
    is = model_issue();
    rq = model_request();
    if (m_pend.size() > 0) begin
      if (s && rq.prio > m_pend[0].prio) m_pend[0] = rq;
      else if (!s) m_pend.delete();
    end else if (s && rq.prio > 0) begin
      m_pend.push_back(rq);
    end
    if (is.prio > 0) begin
      m_last = is.tgt;
      if (is.tgt == HALT_ADDR) begin m_halted = 1'b1; m_pend.delete(); end
    end
  endfunction

  // Advance one clock: model follows the DUT edge, inputs change 1 time unit later.
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  // Evaluate the model for the current inputs and move to the sampling point.
  task automatic settle();
    model_eval();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    stall_req = 0; fetch_stall = 0; br_req = 0; j_req = 0; exc_req = 0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    clear_inputs();
    rst = 1; model_reset();
    repeat (3) tick();
    settle();
    tests_run++;
    if (obs_vec !== {32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      $display("FAIL reset_values: got %h want %h", obs_vec, {32'h0, 6'b001000});
      tests_failed++;
    end
    tick();
    rst = 0;
    for (int c = 0; c < BOOT_CYCLES + 1; c++) begin
      settle();
      tests_run++;
      if (c < BOOT_CYCLES && !(PC_Stall === 1'b1 && active === 1'b0)) begin
        $display("FAIL boot_stall cyc%0d: PC_Stall=%b active=%b want 1/0", c, PC_Stall, active);
        tests_failed++;
      end else if (c == BOOT_CYCLES && !(PC_Stall === 1'b0 && active === 1'b1)) begin
        $display("FAIL boot_release: PC_Stall=%b active=%b want 0/1", PC_Stall, active);
        tests_failed++;
      end
      tick();
    end
  endtask

  task automatic test_branch();
    clear_inputs();
    br_req = 1; br_target = 32'h40;
    settle();
    tests_run++;
    if (!(branch_en === 1 && jump_en === 0 && PC_JVal === 32'h40 && flush === 0) || obs_vec !== exp_vec) begin
      $display("FAIL branch_issue: got %h want %h", obs_vec, exp_vec);
      tests_failed++;
    end
    tick();
    br_req = 0;
    settle();
    tests_run++;
    if (branch_en !== 1'b0 || PC_JVal !== 32'h40 || obs_vec !== exp_vec) begin
      $display("FAIL branch_pulse_end: got %h want %h", obs_vec, exp_vec);
      tests_failed++;
    end
    tick();
  endtask

  task automatic test_jump_stall();
    clear_inputs();
    j_req = 1; j_target = 32'h80; stall_req = 1;
    for (int c = 0; c < 4; c++) begin
      settle();
      tests_run++;
      if (!(PC_Stall === 1 && branch_en === 0 && jump_en === 0) || obs_vec !== exp_vec) begin
        $display("FAIL jump_parked cyc%0d: got %h want %h", c, obs_vec, exp_vec);
        tests_failed++;
      end
      tick();
      j_req = 0;
    end
    stall_req = 0;
    settle();
    tests_run++;
    if (!(jump_en === 1 && branch_en === 0 && PC_JVal === 32'h80 && PC_Stall === 0) || obs_vec !== exp_vec) begin
      $display("FAIL jump_release: got %h want %h", obs_vec, exp_vec);
      tests_failed++;
    end
    tick();
    settle();
    tests_run++;
    if (jump_en !== 1'b0 || obs_vec !== exp_vec) begin
      $display("FAIL jump_pulse_end: got %h want %h", obs_vec, exp_vec);
      tests_failed++;
    end
    tick();
  endtask

  task automatic test_priority();
    clear_inputs();
    exc_req = 1; j_req = 1; br_req = 1; j_target = 32'h1234; br_target = 32'h5678;
    settle();
    tests_run++;
    if (!(jump_en === 1 && branch_en === 0 && flush === 1 && PC_JVal === EXC_VECTOR) || obs_vec !== exp_vec) begin
      $display("FAIL exc_priority: got %h want %h", obs_vec, exp_vec);
      tests_failed++;
    end
    tick();
    clear_inputs();
    stall_req = 1; br_req = 1; br_target = 32'h100;
    settle(); tick();
    br_req = 0; j_req = 1; j_target = 32'h200;
    settle(); tick();
    j_req = 0; br_req = 1; br_target = 32'h300;   // lower priority: must not replace
    settle(); tick();
    clear_inputs();
    settle();
    tests_run++;
    if (!(jump_en === 1 && branch_en === 0 && flush === 0 && PC_JVal === 32'h200) || obs_vec !== exp_vec) begin
      $display("FAIL pend_replace: got %h want %h", obs_vec, exp_vec);
      tests_failed++;
    end
    tick();
  endtask

  task automatic test_halt();
    clear_inputs();
    j_req = 1; j_target = HALT_ADDR;
    settle();
    tests_run++;
    if (!(jump_en === 1 && PC_JVal === HALT_ADDR) || obs_vec !== exp_vec) begin
      $display("FAIL halt_jump: got %h want %h", obs_vec, exp_vec);
      tests_failed++;
    end
    tick();
    for (int c = 0; c < 4; c++) begin
      j_req = 1; br_req = 1; exc_req = (c == 2); j_target = 32'h44; br_target = 32'h88;
      settle();
      tests_run++;
      if (!(active === 0 && halted === 1 && PC_Stall === 1 && jump_en === 0 && branch_en === 0)
          || obs_vec !== exp_vec) begin
        $display("FAIL halt_hold cyc%0d: got %h want %h", c, obs_vec, exp_vec);
        tests_failed++;
      end
      tick();
    end
  endtask

  task automatic test_reset_pend();
    clear_inputs();
    rst = 1; model_reset(); tick(); tick(); rst = 0;
    repeat (BOOT_CYCLES) tick();
    fetch_stall = 1; j_req = 1; j_target = 32'h300;
    tick();
    j_req = 0;
    #2 rst = 1; model_reset();
    #1;
    tests_run++;
    if (obs_vec !== {32'h0, 6'b001000}) begin
      $display("FAIL reset_in_pend: got %h want %h", obs_vec, {32'h0, 6'b001000});
      tests_failed++;
    end
    tick();
    rst = 0; fetch_stall = 0;
    for (int c = 0; c < BOOT_CYCLES + 5; c++) begin
      settle();
      tests_run++;
      if (branch_en !== 0 || jump_en !== 0 || PC_JVal !== 32'h0 || obs_vec !== exp_vec) begin
        $display("FAIL no_stale_redirect cyc%0d: got %h want %h", c, obs_vec, exp_vec);
        tests_failed++;
      end
      tick();
    end
  endtask

  task automatic test_random();
    int halt_cycles = 0;
    for (int c = 0; c < 600; c++) begin
      if (halt_cycles > 3) begin
        clear_inputs(); rst = 1; model_reset(); halt_cycles = 0;
      end else begin
        rst = 0;
      end
      stall_req   = ($urandom_range(0, 9) < 3);
      fetch_stall = ($urandom_range(0, 9) < 2);
      br_req      = ($urandom_range(0, 3) == 0);
      j_req       = ($urandom_range(0, 3) == 0);
      exc_req     = ($urandom_range(0, 9) == 0);
      br_target   = ($urandom_range(0, 15) == 0) ? 32'h0 : $urandom;
      j_target    = ($urandom_range(0, 15) == 0) ? 32'h0 : $urandom;
      settle();
      tests_run++;
      if (obs_vec !== exp_vec) begin
        $display("FAIL random cyc%0d: got %h want %h", c, obs_vec, exp_vec);
        tests_failed++;
      end
      if (m_halted) halt_cycles++;
      tick();
    end
    rst = 0;
  endtask

  initial begin
    model_reset();
    #1;
    test_reset();
    test_branch();
    test_jump_stall();
    test_priority();
    test_halt();
    test_reset_pend();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
